usb_bulk_in_buffer: RTL and testbench



---
 rtl/usb_bulk_in_buffer.sv | 177 +++++++++++++++++
 tb/tb_usb_bulk_in_buffer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bulk_in_buffer.sv
// Packet FIFO for the USB bulk IN path. The user byte stream is cut into
// packets of at most MAX_PKT_SIZE bytes. Committed packets are streamed
// first-word-fall-through with no bubbles, and a packet is released only
// when the host ACKs it. Any other outcome rewinds the read pointer so the
// same packet is sent again on the next IN token.
module usb_bulk_in_buffer #(
   parameter int ADDR_WIDTH   = 11,
   parameter int MAX_PKT_SIZE = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   input  logic [7:0]            s_tdata,
   input  logic                  blk_in_xfer_i,
   input  logic                  rx_trn_hsk_recv,
   input  logic [1:0]            rx_trn_hsk_type,
   output logic                  bid_has_data_o,
   output logic                  bid_tvalid_o,
   input  logic                  bid_tready_i,
   output logic                  bid_tlast_o,
   output logic [7:0]            bid_tdata_o,
   output logic [ADDR_WIDTH:0]   level_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_LEVEL   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] PKT_LAST_CNT = (ADDR_WIDTH + 1)'(MAX_PKT_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_HSK = 2'd2
   } state_t;

   // Each word is {last, data}
   logic [8:0]            mem [DEPTH];
   logic [8:0]            rd_word_reg;

   logic [ADDR_WIDTH:0]   wr_ptr_reg;
   logic [ADDR_WIDTH:0]   wr_commit_reg;
   logic [ADDR_WIDTH:0]   pkt_cnt_reg;
   logic [ADDR_WIDTH:0]   rd_ptr_reg;
   logic [ADDR_WIDTH:0]   rd_commit_reg;
   logic [ADDR_WIDTH:0]   rd_ptr_next;
   logic [ADDR_WIDTH:0]   rd_commit_next;

   logic                  head_ok_reg;
   logic                  has_data_reg;
   logic                  xfer_prev_reg;

   state_t                state_reg;
   state_t                state_next;

   logic                  wr_en;
   logic                  wr_last;
   logic                  accept;
   logic                  rewind;
   logic                  ack;

   // Occupancy counts everything not yet ACKed, so only ACKs free space
   assign level_o        = wr_ptr_reg - rd_commit_reg;
   assign s_tready       = (level_o != FULL_LEVEL);
   assign wr_en          = s_tvalid && s_tready;
   assign wr_last        = s_tlast || (pkt_cnt_reg == PKT_LAST_CNT);
   assign bid_has_data_o = has_data_reg;

   // Write pointer, packet length counter and commit point
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         wr_commit_reg <= '0;
         pkt_cnt_reg   <= '0;
      end else if (wr_en) begin
         wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (wr_last) begin
            wr_commit_reg <= wr_ptr_reg + 1'b1;
            pkt_cnt_reg   <= '0;
         end else begin
            pkt_cnt_reg <= pkt_cnt_reg + 1'b1;
         end
      end
   end

   // Packet RAM; the read address is the pointer the read side will hold next cycle
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= {wr_last, s_tdata};
      end
      rd_word_reg <= mem[rd_ptr_next[ADDR_WIDTH-1:0]];
   end

   // Read pointers and status flags; head_ok marks that the fetched word was committed when read
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg    <= '0;
         rd_commit_reg <= '0;
         head_ok_reg   <= 1'b0;
         has_data_reg  <= 1'b0;
         xfer_prev_reg <= 1'b0;
      end else begin
         rd_ptr_reg    <= rd_ptr_next;
         rd_commit_reg <= rd_commit_next;
         head_ok_reg   <= (rd_ptr_next != wr_commit_reg);
         has_data_reg  <= (wr_commit_reg != rd_commit_reg);
         xfer_prev_reg <= blk_in_xfer_i;
      end
   end

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Read FSM next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (blk_in_xfer_i && !xfer_prev_reg) begin
               state_next = SEND;
            end
         end
         SEND: begin
            if (!blk_in_xfer_i) begin
               state_next = IDLE;
            end else if (accept && rd_word_reg[8]) begin
               state_next = WAIT_HSK;
            end
         end
         WAIT_HSK: begin
            if (rx_trn_hsk_recv || !blk_in_xfer_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Read FSM outputs and pointer moves (rewind wins over a same-cycle accept)
   always_comb begin
      bid_tvalid_o = head_ok_reg && (state_reg != WAIT_HSK);
      bid_tlast_o  = bid_tvalid_o && rd_word_reg[8];
      bid_tdata_o  = bid_tvalid_o ? rd_word_reg[7:0] : 8'h00;
      accept       = (state_reg == SEND) && bid_tvalid_o && bid_tready_i;
      rewind       = 1'b0;
      ack          = 1'b0;
      case (state_reg)
         SEND: begin
            rewind = !blk_in_xfer_i;
         end
         WAIT_HSK: begin
            if (rx_trn_hsk_recv) begin
               ack    = (rx_trn_hsk_type == 2'b00);
               rewind = (rx_trn_hsk_type != 2'b00);
            end else begin
               rewind = !blk_in_xfer_i;
            end
         end
         default: ;
      endcase
      if (rewind) begin
         rd_ptr_next = rd_commit_reg;
      end else if (accept) begin
         rd_ptr_next = rd_ptr_reg + 1'b1;
      end else begin
         rd_ptr_next = rd_ptr_reg;
      end
      rd_commit_next = ack ? rd_ptr_reg : rd_commit_reg;
   end

endmodule

// File: tb/tb_usb_bulk_in_buffer.sv
// Self-checking bench for usb_bulk_in_buffer. A packet-level model (byte
// queue plus committed packet lengths) predicts every streamed byte, the
// tlast positions, occupancy and the advertise flag.
module tb_usb_bulk_in_buffer;

   localparam int AW    = 11;
   localparam int MAXP  = 512;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [7:0]    s_tdata = 8'h00;
   logic          blk_in_xfer_i = 1'b0;
   logic          rx_trn_hsk_recv = 1'b0;
   logic [1:0]    rx_trn_hsk_type = 2'b00;
   logic          bid_has_data_o;
   logic          bid_tvalid_o;
   logic          bid_tready_i = 1'b0;
   logic          bid_tlast_o;
   logic [7:0]    bid_tdata_o;
   logic [AW:0]   level_o;

   int checks = 0;
   int errors = 0;

   // model: all unfreed bytes in order, lengths of committed packets, open packet size
   logic [7:0]    data_q[$];
   int            len_q[$];
   int            part_cnt = 0;

   usb_bulk_in_buffer #(.ADDR_WIDTH(AW), .MAX_PKT_SIZE(MAXP)) dut (
      .clk             (clk),
      .rst             (rst),
      .s_tvalid        (s_tvalid),
      .s_tready        (s_tready),
      .s_tlast         (s_tlast),
      .s_tdata         (s_tdata),
      .blk_in_xfer_i   (blk_in_xfer_i),
      .rx_trn_hsk_recv (rx_trn_hsk_recv),
      .rx_trn_hsk_type (rx_trn_hsk_type),
      .bid_has_data_o  (bid_has_data_o),
      .bid_tvalid_o    (bid_tvalid_o),
      .bid_tready_i    (bid_tready_i),
      .bid_tlast_o     (bid_tlast_o),
      .bid_tdata_o     (bid_tdata_o),
      .level_o         (level_o)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_write(input logic [7:0] d, input bit l);
      data_q.push_back(d);
      part_cnt++;
      if (l || part_cnt == MAXP) begin
         len_q.push_back(part_cnt);
         part_cnt = 0;
      end
   endfunction

   function automatic void model_ack();
      int n;
      n = len_q.pop_front();
      for (int k = 0; k < n; k++) void'(data_q.pop_front());
   endfunction

   function automatic void model_clear();
      data_q.delete();
      len_q.delete();
      part_cnt = 0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      blk_in_xfer_i = 1'b0;
      rx_trn_hsk_recv = 1'b0;
      bid_tready_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic wr_byte(input logic [7:0] d, input bit l, output bit took);
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      took     = s_tready;
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (took) model_write(d, l);
   endtask

   // base < 0 selects random bytes, otherwise base, base+1, ...
   task automatic send_bytes(input int n, input bit last_at_end, input bit gaps, input int base);
      logic [7:0] d;
      bit         l;
      bit         took;
      int         tries;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(3) == 0) @(negedge clk);
         d = (base < 0) ? 8'($urandom) : 8'(base + i);
         l = last_at_end && (i == n - 1);
         tries = 0;
         took = 1'b0;
         while (!took && tries < 100) begin
            wr_byte(d, l, took);
            tries++;
         end
         if (!took) begin
            checks++;
            errors++;
            $display("FAIL write_accept byte %0d: s_tready stayed 0, required 1", i);
         end
      end
   endtask

   // One bulk IN: mode 0 = ACK, 1 = NAK, 2 = drop transfer without handshake
   task automatic do_in(input int mode);
      int n;
      int wait_cyc;
      logic exp_last;
      wait_cyc = 0;
      @(negedge clk);
      while (!bid_has_data_o && wait_cyc < 200) begin
         @(negedge clk);
         wait_cyc++;
      end
      checks++;
      if (bid_has_data_o !== (len_q.size() != 0)) begin
         errors++;
         $display("FAIL has_data_before_in got=%b exp=%b", bid_has_data_o, len_q.size() != 0);
         return;
      end
      if (len_q.size() == 0) return;
      n = len_q[0];
      checks++;
      if (bid_tvalid_o !== 1'b1 || bid_tdata_o !== data_q[0]) begin
         errors++;
         $display("FAIL idle_head got valid=%b data=%h exp valid=1 data=%h",
                  bid_tvalid_o, bid_tdata_o, data_q[0]);
      end
      blk_in_xfer_i = 1'b1;
      bid_tready_i  = 1'b1;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         exp_last = (i == n - 1);
         checks++;
         if (bid_tvalid_o !== 1'b1 || bid_tdata_o !== data_q[i] || bid_tlast_o !== exp_last) begin
            errors++;
            $display("FAIL stream byte %0d/%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                     i, n, bid_tvalid_o, bid_tdata_o, bid_tlast_o, data_q[i], exp_last);
         end
      end
      @(negedge clk);
      bid_tready_i = 1'b0;
      checks++;
      if (bid_tvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL wait_hsk_valid got=%b exp=0", bid_tvalid_o);
      end
      if (mode == 2) begin
         blk_in_xfer_i = 1'b0;
      end else begin
         rx_trn_hsk_recv = 1'b1;
         rx_trn_hsk_type = (mode == 0) ? 2'b00 : 2'b10;
         @(negedge clk);
         rx_trn_hsk_recv = 1'b0;
         rx_trn_hsk_type = 2'b00;
         blk_in_xfer_i   = 1'b0;
         if (mode == 0) model_ack();
      end
      if (mode == 2) @(negedge clk);
      checks++;
      if (level_o !== (AW + 1)'(data_q.size())) begin
         errors++;
         $display("FAIL level_after_in mode %0d got=%0d exp=%0d", mode, level_o, data_q.size());
      end
   endtask

   task automatic check_drained(input string tag);
      @(negedge clk);
      checks++;
      if (bid_has_data_o !== 1'b0 || level_o !== '0 || bid_tvalid_o !== 1'b0) begin
         errors++;
         $display("FAIL %s drained got has=%b lvl=%0d v=%b exp has=0 lvl=0 v=0",
                  tag, bid_has_data_o, level_o, bid_tvalid_o);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready got=%b exp=1", s_tready); end
      checks++;
      if (bid_has_data_o !== 1'b0) begin errors++; $display("FAIL reset_has_data got=%b exp=0", bid_has_data_o); end
      checks++;
      if (bid_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", bid_tvalid_o); end
      checks++;
      if (bid_tlast_o !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", bid_tlast_o); end
      checks++;
      if (bid_tdata_o !== 8'h00) begin errors++; $display("FAIL reset_tdata got=%h exp=00", bid_tdata_o); end
      checks++;
      if (level_o !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_o); end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      send_bytes(10, 1'b1, 1'b0, 0);
      @(negedge clk);
      checks++;
      if (bid_has_data_o !== 1'b0) begin errors++; $display("FAIL basic_has_data_early got=%b exp=0", bid_has_data_o); end
      @(negedge clk);
      checks++;
      if (bid_has_data_o !== 1'b1) begin errors++; $display("FAIL basic_has_data got=%b exp=1", bid_has_data_o); end
      do_in(0);
      check_drained("basic");
      $display("test_basic done");
   endtask

   task automatic test_split();
      send_bytes(1200, 1'b1, 1'b1, -1);
      for (int p = 0; p < 3; p++) do_in(0);
      check_drained("split");
      $display("test_split done");
   endtask

   task automatic test_replay_drop();
      send_bytes(20, 1'b1, 1'b1, -1);
      do_in(2);
      do_in(0);
      check_drained("replay_drop");
      $display("test_replay_drop done");
   endtask

   task automatic test_nak();
      send_bytes(20, 1'b1, 1'b0, -1);
      do_in(1);
      do_in(0);
      check_drained("nak");
      $display("test_nak done");
   endtask

   task automatic test_full();
      bit took;
      send_bytes(DEPTH, 1'b0, 1'b0, -1);
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0 || level_o !== (AW + 1)'(DEPTH)) begin
         errors++;
         $display("FAIL full_state got rdy=%b lvl=%0d exp rdy=0 lvl=%0d", s_tready, level_o, DEPTH);
      end
      wr_byte(8'h55, 1'b0, took);
      checks++;
      if (took !== 1'b0) begin errors++; $display("FAIL full_reject got accepted=%b exp=0", took); end
      do_in(0);
      checks++;
      if (s_tready !== 1'b1) begin errors++; $display("FAIL full_ready_after_ack got=%b exp=1", s_tready); end
      for (int p = 0; p < 3; p++) do_in(0);
      check_drained("full");
      $display("test_full done");
   endtask

   task automatic test_back_to_back();
      fork
         begin
            for (int p = 0; p < 4; p++) send_bytes($urandom_range(40, 1), 1'b1, 1'b1, -1);
         end
         begin
            for (int p = 0; p < 4; p++) do_in(0);
         end
      join
      check_drained("back_to_back");
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid();
      send_bytes(20, 1'b1, 1'b0, 8'h40);
      repeat (3) @(negedge clk);
      blk_in_xfer_i = 1'b1;
      bid_tready_i  = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bid_tvalid_o !== 1'b1 || bid_tdata_o !== data_q[i]) begin
            errors++;
            $display("FAIL mid_stream byte %0d got v=%b d=%h exp v=1 d=%h", i, bid_tvalid_o, bid_tdata_o, data_q[i]);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      blk_in_xfer_i = 1'b0;
      bid_tready_i  = 1'b0;
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b1 || bid_has_data_o !== 1'b0 || bid_tvalid_o !== 1'b0 ||
          bid_tlast_o !== 1'b0 || bid_tdata_o !== 8'h00 || level_o !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs got rdy=%b has=%b v=%b l=%b d=%h lvl=%0d exp 1 0 0 0 00 0",
                  s_tready, bid_has_data_o, bid_tvalid_o, bid_tlast_o, bid_tdata_o, level_o);
      end
      rst = 1'b0;
      model_clear();
      send_bytes(3, 1'b1, 1'b0, 8'hA0);
      @(negedge clk);
      checks++;
      if (level_o !== 12'd3) begin errors++; $display("FAIL mid_reset_level got=%0d exp=3", level_o); end
      do_in(0);
      check_drained("reset_mid");
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_split();
      test_replay_drop();
      test_nak();
      test_full();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
